// File: rtl/mv_decim_out_fifo.sv
// Block-averaging decimator with sequence-tagged FWFT output FIFO.
// Optional MV_DECIM_ROUND_EN: round-half-up with 32-bit saturation.
module mv_decim_out_fifo #(
  parameter int DECIM      = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int SHIFT      = $clog2(DECIM),
  parameter int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             en,
  input  logic             trig,
  input  logic [31:0]      din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [7:0]       out_seq,
  output logic [PTR_W:0]   fifo_level,
  output logic             ovf_flag,
  output logic [15:0]      ovf_cnt,
  input  logic             ovf_clr
);

  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_PUSH
  } state_t;

  state_t             state;
  logic signed [47:0] acc;
  logic signed [47:0] sum;
  logic [CNT_W-1:0]   sample_cnt;
  logic [31:0]        word;
  logic [31:0]        word_nxt;
  logic [7:0]         seq;

  logic [39:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_nxt;
  logic [PTR_W:0]     level_nxt;
  logic               push;
  logic               pop;
  logic               full;
  logic               wr_ok;
  logic               drop;
  logic               bypass;

  assign sum = acc + {{16{din[31]}}, din};

`ifdef MV_DECIM_ROUND_EN
  localparam logic signed [47:0] HALF = (48'sd1 <<< SHIFT) >>> 1;
  localparam logic signed [47:0] MAXV = 48'sh0000_7FFF_FFFF;
  localparam logic signed [47:0] MINV = 48'shFFFF_8000_0000;
  logic signed [47:0] rnd;

  always_comb begin
    rnd = (sum + HALF) >>> SHIFT;
    if (rnd > MAXV)
      word_nxt = 32'h7FFF_FFFF;
    else if (rnd < MINV)
      word_nxt = 32'h8000_0000;
    else
      word_nxt = 32'(rnd);
  end
`else
  assign word_nxt = 32'(sum >>> SHIFT);
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= S_IDLE;
      acc        <= '0;
      sample_cnt <= '0;
      word       <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          acc        <= '0;
          sample_cnt <= '0;
          if (en) state <= S_ACC;
        end
        S_ACC: begin
          if (!en) begin
            state      <= S_IDLE;
            acc        <= '0;
            sample_cnt <= '0;
          end else if (trig) begin
            if (sample_cnt == CNT_LAST) begin
              word       <= word_nxt;
              acc        <= '0;
              sample_cnt <= '0;
              state      <= S_PUSH;
            end else begin
              acc        <= sum;
              sample_cnt <= sample_cnt + CNT_W'(1);
            end
          end
        end
        S_PUSH: begin
          acc        <= '0;
          sample_cnt <= '0;
          state      <= en ? S_ACC : S_IDLE;
          // acc is zero here, so sum is just the new sample
          if (en && trig) begin
            if (sample_cnt == CNT_LAST) begin
              word  <= word_nxt;
              state <= S_PUSH;
            end else begin
              acc        <= sum;
              sample_cnt <= CNT_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign push      = (state == S_PUSH);
  assign pop       = out_valid & out_ready;
  assign full      = (fifo_level == (PTR_W+1)'(FIFO_DEPTH));
  assign wr_ok     = push & (~full | pop);
  assign drop      = push & full & ~pop;
  assign rd_nxt    = rd_ptr + PTR_W'(pop);
  assign level_nxt = fifo_level + (PTR_W+1)'(wr_ok)
                   - (PTR_W+1)'(pop);
  // new word becomes head when nothing else remains after this pop
  assign bypass    = wr_ok & (fifo_level == (PTR_W+1)'(pop));

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= {seq, word};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_seq    <= '0;
      seq        <= '0;
      ovf_flag   <= 1'b0;
      ovf_cnt    <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr     <= rd_nxt;
      fifo_level <= level_nxt;
      out_valid  <= (level_nxt != '0);
      if (bypass)
        {out_seq, out_data} <= {seq, word};
      else if (level_nxt != '0)
        {out_seq, out_data} <= mem[rd_nxt];
      if (push) seq <= seq + 8'd1;
      if (ovf_clr) begin
        ovf_flag <= 1'b0;
        ovf_cnt  <= '0;
      end else if (drop) begin
        ovf_flag <= 1'b1;
        if (ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mv_decim_out_fifo.sv
// Bench for mv_decim_out_fifo: directed scenarios plus random
// traffic checked against a queue-based reference model.
module tb_mv_decim_out_fifo;

  localparam int DECIM = 4;
  localparam int FD    = 4;
  localparam int PW    = $clog2(FD);

`ifdef MV_DECIM_ROUND_EN
  localparam logic [31:0] EXP_POS = 32'd26;
  localparam logic [31:0] EXP_NEG = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] EXP_POS = 32'd25;
  localparam logic [31:0] EXP_NEG = 32'hFFFF_FFFE;
`endif

  logic          clk;
  logic          n_rst;
  logic          en;
  logic          trig;
  logic [31:0]   din;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [7:0]    out_seq;
  logic [PW:0]   fifo_level;
  logic          ovf_flag;
  logic [15:0]   ovf_cnt;
  logic          ovf_clr;

  int n_cmp = 0;
  int n_bad = 0;

  mv_decim_out_fifo #(.DECIM(DECIM), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .n_rst(n_rst), .en(en), .trig(trig), .din(din),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_seq(out_seq),
    .fifo_level(fifo_level), .ovf_flag(ovf_flag),
    .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [39:0] mq[$];
  longint      m_win[$];
  logic [7:0]  m_seq;
  logic [7:0]  m_hseq;
  logic [31:0] m_hdata;
  logic [31:0] m_pword;
  bit          m_pend;
  bit          m_en_prev;
  bit          m_flag;
  int          m_cnt;

  function automatic logic [31:0] avg(input longint s);
    longint q;
    longint v;
    v = s;
`ifdef MV_DECIM_ROUND_EN
    if (DECIM > 1) v = v + DECIM / 2;
`endif
    q = v / DECIM;
    if ((v % DECIM) != 0 && v < 0) q = q - 1;
`ifdef MV_DECIM_ROUND_EN
    if (q > 64'sd2147483647) q = 64'sd2147483647;
    if (q < -64'sd2147483648) q = -64'sd2147483648;
`endif
    return 32'(q);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_win.delete();
    m_seq = 0; m_hseq = 0; m_hdata = 0; m_pword = 0;
    m_pend = 0; m_en_prev = 0; m_flag = 0; m_cnt = 0;
  endtask

  task automatic step(input bit e, input bit t,
                      input logic [31:0] d,
                      input bit r, input bit c);
    bit     pop;
    bit     full;
    bit     drop;
    longint s;
    en = e; trig = t; din = d; out_ready = r; ovf_clr = c;
    @(posedge clk);
    pop  = (mq.size() != 0) && r;
    full = (mq.size() == FD);
    drop = 0;
    if (pop) void'(mq.pop_front());
    if (m_pend) begin
      if (!full || pop) mq.push_back({m_seq, m_pword});
      else drop = 1;
      m_seq = m_seq + 8'd1;
    end
    if (c) begin
      m_flag = 0; m_cnt = 0;
    end else if (drop) begin
      m_flag = 1;
      if (m_cnt < 65535) m_cnt++;
    end
    m_pend = 0;
    if (!e) m_win.delete();
    else if (m_en_prev && t) begin
      m_win.push_back(longint'($signed(d)));
      if (m_win.size() == DECIM) begin
        s = 0;
        foreach (m_win[i]) s += m_win[i];
        m_pword = avg(s);
        m_pend  = 1;
        m_win.delete();
      end
    end
    m_en_prev = e;
    if (mq.size() != 0) {m_hseq, m_hdata} = mq[0];
    #1;
  endtask

  task automatic do_reset();
    en = 0; trig = 0; din = 0; out_ready = 0; ovf_clr = 0;
    n_rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 n_rst = 1'b1;
  endtask

  task automatic test_reset();
    en = 0; trig = 0; din = 0; out_ready = 0; ovf_clr = 0;
    n_rst = 1'b1;
    #2 n_rst = 1'b0;
    #1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_valid: got %b want 0", out_valid);
    end
    n_cmp++;
    if (out_data !== 32'd0) begin
      n_bad++; $display("FAIL rst_data: got %h want 0", out_data);
    end
    n_cmp++;
    if (out_seq !== 8'd0) begin
      n_bad++; $display("FAIL rst_seq: got %h want 0", out_seq);
    end
    n_cmp++;
    if (fifo_level !== '0) begin
      n_bad++; $display("FAIL rst_level: got %0d want 0", fifo_level);
    end
    n_cmp++;
    if (ovf_flag !== 1'b0 || ovf_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL rst_ovf: got %b/%0d want 0/0", ovf_flag, ovf_cnt);
    end
    #2 n_rst = 1'b1;
  endtask

  task automatic test_floor();
    step(1, 0, 0, 0, 0);
    step(1, 1, 32'd10, 0, 0);
    step(1, 1, 32'd20, 0, 0);
    step(1, 1, 32'd30, 0, 0);
    step(1, 1, 32'd42, 0, 0);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL floor_early: got %b want 0", out_valid);
    end
    step(1, 0, 0, 0, 0);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++; $display("FAIL floor_valid: got %b want 1", out_valid);
    end
    n_cmp++;
    if (out_data !== EXP_POS) begin
      n_bad++;
      $display("FAIL floor_data: got %0d want %0d", out_data, EXP_POS);
    end
    n_cmp++;
    if (out_seq !== 8'd0 || fifo_level !== 1) begin
      n_bad++;
      $display("FAIL floor_seq: got seq %0d lvl %0d want 0/1",
               out_seq, fifo_level);
    end
    step(1, 0, 0, 1, 0);
    n_cmp++;
    if (out_valid !== 1'b0 || fifo_level !== 0) begin
      n_bad++;
      $display("FAIL floor_pop: got v%b lvl %0d want 0/0",
               out_valid, fifo_level);
    end
    n_cmp++;
    if (out_data !== EXP_POS) begin
      n_bad++;
      $display("FAIL floor_hold: got %0d want %0d", out_data, EXP_POS);
    end
  endtask

  task automatic test_negative();
    step(1, 1, 32'hFFFF_FFFF, 0, 0);
    step(1, 1, 32'hFFFF_FFFF, 0, 0);
    step(1, 1, 32'hFFFF_FFFF, 0, 0);
    step(1, 1, 32'hFFFF_FFFE, 0, 0);
    step(1, 0, 0, 0, 0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== EXP_NEG) begin
      n_bad++;
      $display("FAIL neg_data: got v%b %h want 1 %h",
               out_valid, out_data, EXP_NEG);
    end
    n_cmp++;
    if (out_seq !== 8'd1) begin
      n_bad++; $display("FAIL neg_seq: got %0d want 1", out_seq);
    end
    step(1, 0, 0, 1, 0);
  endtask

  task automatic test_overflow();
    do_reset();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5 * DECIM; i++)
      step(1, 1, 32'($urandom_range(0, 1000)) - 32'd500, 0, 0);
    step(1, 0, 0, 0, 0);
    n_cmp++;
    if (fifo_level !== FD) begin
      n_bad++; $display("FAIL ovf_level: got %0d want %0d", fifo_level, FD);
    end
    n_cmp++;
    if (ovf_flag !== 1'b1 || ovf_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL ovf_count: got %b/%0d want 1/1", ovf_flag, ovf_cnt);
    end
    for (int i = 0; i < FD; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_seq !== 8'(i)
          || out_data !== m_hdata) begin
        n_bad++;
        $display("FAIL ovf_drain%0d: got v%b seq %0d %h want 1 %0d %h",
                 i, out_valid, out_seq, out_data, i, m_hdata);
      end
      step(1, 0, 0, 1, 0);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL ovf_empty: got %b want 0", out_valid);
    end
    for (int i = 0; i < DECIM; i++) step(1, 1, 32'(i), 0, 0);
    step(1, 0, 0, 0, 0);
    n_cmp++;
    if (out_seq !== 8'd5) begin
      n_bad++; $display("FAIL ovf_gap: got seq %0d want 5", out_seq);
    end
    step(1, 0, 0, 0, 1);
    n_cmp++;
    if (ovf_flag !== 1'b0 || ovf_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL ovf_clr: got %b/%0d want 0/0", ovf_flag, ovf_cnt);
    end
    step(1, 0, 0, 1, 0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] s0;
    s0 = m_seq;
    for (int i = 0; i < FD * DECIM; i++)
      step(1, 1, $urandom, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3 * DECIM; i++) begin
      if (m_pend) begin
        step(1, 1, $urandom, 1, 0);
        n_cmp++;
        if (fifo_level !== FD || ovf_cnt !== 16'd0) begin
          n_bad++;
          $display("FAIL b2b_full: got lvl %0d ovf %0d want %0d/0",
                   fifo_level, ovf_cnt, FD);
        end
      end else begin
        step(1, 1, $urandom, 0, 0);
      end
    end
    if (m_pend) step(1, 0, 0, 1, 0);
    for (int i = 0; i < FD; i++) begin
      n_cmp++;
      if (out_seq !== 8'(s0 + 8'd3 + 8'(i)) || out_data !== m_hdata) begin
        n_bad++;
        $display("FAIL b2b_seq%0d: got %0d %h want %0d %h", i, out_seq,
                 out_data, 8'(s0 + 8'd3 + 8'(i)), m_hdata);
      end
      step(1, 0, 0, 1, 0);
    end
  endtask

  task automatic test_abort();
    do_reset();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 32'd100, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < DECIM; i++) step(1, 1, 32'd8, 0, 0);
    repeat (4) step(1, 0, 0, 0, 0);
    n_cmp++;
    if (fifo_level !== 1 || out_data !== 32'd8 || out_seq !== 8'd0) begin
      n_bad++;
      $display("FAIL abort_word: got lvl %0d data %0d seq %0d want 1/8/0",
               fifo_level, out_data, out_seq);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 2 * DECIM + 2; i++)
      step(1, 1, $urandom, 0, 0);
    n_cmp++;
    if (fifo_level !== 2) begin
      n_bad++; $display("FAIL rmid_pre: got %0d want 2", fifo_level);
    end
    #2 n_rst = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || out_seq !== 8'd0
        || fifo_level !== 0 || ovf_flag !== 1'b0 || ovf_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL rmid_zero: got v%b %h s%0d l%0d f%b c%0d want zeros",
               out_valid, out_data, out_seq, fifo_level, ovf_flag, ovf_cnt);
    end
    en = 0; trig = 0;
    @(posedge clk);
    #3 n_rst = 1'b1;
    step(1, 0, 0, 0, 0);
    for (int i = 1; i <= DECIM; i++) step(1, 1, 32'(4 * i), 0, 0);
    step(1, 0, 0, 0, 0);
    n_cmp++;
    if (fifo_level !== 1 || out_seq !== 8'd0 || out_data !== 32'd10) begin
      n_bad++;
      $display("FAIL rmid_fresh: got l%0d s%0d %0d want 1/0/10",
               fifo_level, out_seq, out_data);
    end
  endtask

  task automatic test_random();
    int pct;
    bit e;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n % 400 == 0) pct = $urandom_range(0, 3) * 30;
      e = ($urandom_range(0, 39) != 0);
      step(e, 1'($urandom_range(0, 1)), $urandom,
           ($urandom_range(0, 99) < pct),
           ($urandom_range(0, 149) == 0));
      n_cmp++;
      if (out_valid !== (mq.size() != 0)
          || fifo_level !== (PW+1)'(mq.size())
          || out_data !== m_hdata || out_seq !== m_hseq
          || ovf_flag !== m_flag || ovf_cnt !== 16'(m_cnt)) begin
        n_bad++;
        $display("FAIL rand%0d: got v%b l%0d %h s%0d f%b c%0d want v%b l%0d %h s%0d f%b c%0d",
                 n, out_valid, fifo_level, out_data, out_seq,
                 ovf_flag, ovf_cnt, mq.size() != 0, mq.size(),
                 m_hdata, m_hseq, m_flag, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_floor();
    test_negative();
    test_overflow();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mv_decim_out_fifo.md
Name: mv_decim_out_fifo

Overview:
- Output stage directly downstream of the moving-average filter.
- Consumes filtered samples (din qualified by a single-cycle trig) and block-averages every DECIM samples into one decimated word.
- Tags each word with a sequence number and buffers it in a small FIFO.
- The host-interface packetizer drains the FIFO over a valid/ready handshake.

Parameters:
- DECIM, 16: samples per output word; power of 2, >=1 (1 = pass-through, no shift).
- FIFO_DEPTH, 16: output FIFO entries; power of 2, >=2.
- SHIFT, $clog2(DECIM): derived; arithmetic right shift applied to the sum.
- PTR_W, $clog2(FIFO_DEPTH): derived; FIFO pointer width.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- en  in  1  accumulate enable; low forces S_IDLE
- trig  in  1  single-cycle strobe; din is valid in this cycle
- din  in  32  signed filtered sample
- out_valid  out  1  FIFO head word available
- out_ready  in  1  consumer accepts head word when out_valid&out_ready
- out_data  out  32  signed decimated word at FIFO head
- out_seq  out  8  sequence tag of head word
- fifo_level  out  PTR_W+1  current FIFO occupancy
- ovf_flag  out  1  sticky: a word was dropped because FIFO was full
- ovf_cnt  out  16  dropped-word count, saturates at 16'hFFFF
- ovf_clr  in  1  synchronous clear of ovf_flag and ovf_cnt

Behaviour:
- Reset (asynchronous): all outputs 0; FIFO pointers, accumulator, sample counter and seq counter 0; state S_IDLE. Reset mid-window or mid-push discards all content; no partial word is emitted.
- Accumulator: 48-bit signed; din is sign-extended. sample_cnt counts 0..DECIM-1.
- S_IDLE: accumulator and sample_cnt held at 0. Go to S_ACC when en=1. trig is ignored.
- S_ACC:
  - On each trig: acc += din and sample_cnt++.
  - On the trig with sample_cnt==DECIM-1: latch word = (acc+din)>>>SHIFT (floor), clear acc and sample_cnt, go to S_PUSH.
  - en=0 at any time: go to S_IDLE and discard the partial window.
- S_PUSH (one cycle):
  - Write {seq, word} into the FIFO if not full. If full, drop the word, set ovf_flag and increment ovf_cnt.
  - seq increments in both cases, so dropped words show up as gaps.
  - A trig in this cycle is accumulated as the first sample of the next window (acc = din, sample_cnt = 1).
  - Next state: S_ACC if en, else S_IDLE.
- Latency: last trig at cycle t -> push at edge t+1 -> out_valid=1 at t+2 if the FIFO was empty.
- FIFO:
  - First-word-fall-through: out_data and out_seq always reflect the head; both are registered.
  - Pop occurs when out_valid&out_ready.
  - Push and pop in the same cycle when full: both accepted, no drop, level unchanged.
  - Push and pop in the same cycle when level=1: head updates to the new word, out_valid stays 1.
  - Pointers wrap modulo FIFO_DEPTH; fifo_level is exact 0..FIFO_DEPTH.
  - out_data holds its last value when empty.
- ovf_clr=1 clears ovf_flag/ovf_cnt. If it coincides with a drop, the clear wins and the drop is not counted.
- en has no effect on FIFO drain.

Optional Feature:
- MV_DECIM_ROUND_EN defined:
  - Word = (acc + (1<<(SHIFT-1))) >>> SHIFT, i.e. round-half-up, then saturated to [-2^31, 2^31-1].
  - DECIM=1 bypasses rounding.
- Not defined: plain floor truncation, no rounding adder, no saturation logic.

Test Plan:
- Floor averaging (DECIM=4, en=1): trig with din 10,20,30,42 -> one word 25, seq 0. With MV_DECIM_ROUND_EN the word is 26.
- Negative values (DECIM=4): din -1,-1,-1,-2 -> word -2 (floor). With MV_DECIM_ROUND_EN the word is -1.
- Overflow (DECIM=2, FIFO_DEPTH=4, out_ready=0): feed 10 samples -> fifo_level=4, ovf_flag=1, ovf_cnt=1.
  - Then out_ready=1 -> 4 words drain with seq 0..3.
  - Next generated word has seq 5.
  - ovf_clr pulse -> ovf_flag=0, ovf_cnt=0.
- Back-to-back: FIFO full with out_ready=1 continuously and pushes arriving -> no drops, level stays 4, seq contiguous.
- Window abort: 3 of 4 trigs, drop en for 1 cycle, re-raise en, then 4 trigs of 8 -> single word 8; the partial window is discarded.
- Async reset mid-window with FIFO level 2 -> all outputs 0 immediately. After release, the first word has seq 0 and is formed from fresh samples only.
